// File: rtl/param_sync_snapshot_pkg.sv
// ---------------------------------------------------------------------------
// param_sync_pkg
// Shared definitions for the parameter snapshot block: default parameter
// values, the per-channel value type and the slew helper used when
// SLEW_LIMIT_EN is defined.
// No ports (package).
// ---------------------------------------------------------------------------
package param_sync_pkg;

  localparam int DEF_NUM_CH        = 12;
  localparam int DEF_WIDTH         = 10;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_MAX_STEP      = 16;

  typedef logic [DEF_WIDTH-1:0] param_t;

  // Moves cur toward tgt by at most step. The arithmetic is done in 32 bits,
  // which is wider than any channel, so it cannot wrap at either end of the
  // channel range.
  function automatic int unsigned slew_step(input int unsigned cur,
                                            input int unsigned tgt,
                                            input int unsigned step);
    int unsigned diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return cur + ((diff < step) ? diff : step);
    end else begin
      diff = cur - tgt;
      return cur - ((diff < step) ? diff : step);
    end
  endfunction

endpackage

// File: rtl/param_sync_snapshot_if.sv
// ---------------------------------------------------------------------------
// param_sync_snapshot_if
// Groups the frame strobe, the raw control values and the published values.
//   new_frame   one-cycle frame boundary pulse (master -> slave)
//   params_in   NUM_CH*WIDTH raw values, asynchronous (master -> slave)
//   params_out  NUM_CH*WIDTH frame-stable values (slave -> master)
//   changed     NUM_CH per-channel change pulses (slave -> master)
//   settled     all channels stable and published (slave -> master)
// ---------------------------------------------------------------------------
interface param_sync_snapshot_if
  import param_sync_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
);
  logic                    new_frame;
  logic [NUM_CH*WIDTH-1:0] params_in;
  logic [NUM_CH*WIDTH-1:0] params_out;
  logic [NUM_CH-1:0]       changed;
  logic                    settled;

  modport master (
    output new_frame, params_in,
    input  params_out, changed, settled
  );

  modport slave (
    input  new_frame, params_in,
    output params_out, changed, settled
  );
endinterface

// File: rtl/param_sync_snapshot_channel.sv
// ---------------------------------------------------------------------------
// param_sync_channel
// One channel: synchroniser chain, stability filter and frame publish.
//   clk_pixel  pixel clock
//   rst        asynchronous active-high reset
//   new_frame  frame boundary pulse
//   param_in   raw channel value from the foreign domain
//   param_out  value published at the last frame boundary
//   changed    one-cycle pulse when param_out takes a new value
//   filter_ok  filter saturated and its accepted value equals param_out
// Optional feature: macro SLEW_LIMIT_EN limits each publish step to MAX_STEP.
// ---------------------------------------------------------------------------
module param_sync_channel
  import param_sync_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_STEP      = DEF_MAX_STEP
) (
  input  logic             clk_pixel,
  input  logic             rst,
  input  logic             new_frame,
  input  logic [WIDTH-1:0] param_in,
  output logic [WIDTH-1:0] param_out,
  output logic             changed,
  output logic             filter_ok
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(STABLE_CYCLES);

  // Reject illegal configurations at elaboration time.
  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || MAX_STEP < 1) begin : g_bad_params
    $error("param_sync_channel: illegal parameter value");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] next_out;
  logic [CW-1:0]    cnt;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Plain flop chain; the raw input touches nothing but the first stage.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= param_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A value is accepted only after STABLE_CYCLES consecutive matching
  // samples; any mismatch restarts the count so torn values never pass.
  // stable_q loads on the edge where cnt reaches saturation.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      cand     <= '0;
      cnt      <= '0;
      stable_q <= '0;
    end else begin
      cand <= sync_out;
      if (sync_out != cand) begin
        cnt <= '0;
      end else if (cnt != CNT_FULL) begin
        cnt <= cnt + CW'(1);
        if (cnt == CNT_FULL - CW'(1)) stable_q <= cand;
      end
    end
  end

  // Value to publish at the next frame boundary.
  always_comb begin
`ifdef SLEW_LIMIT_EN
    next_out = WIDTH'(slew_step(32'(param_out), 32'(stable_q), 32'(MAX_STEP)));
`else
    next_out = stable_q;
`endif
  end

  // Publish uses the pre-edge stable_q, so an acceptance on the same edge
  // as new_frame waits for the following frame.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      param_out <= '0;
      changed   <= 1'b0;
    end else if (new_frame) begin
      param_out <= next_out;
      changed   <= (next_out != param_out);
    end else begin
      changed   <= 1'b0;
    end
  end

  assign filter_ok = (cnt == CNT_FULL) && (stable_q == param_out);

endmodule

// File: rtl/param_sync_snapshot.sv
// ---------------------------------------------------------------------------
// param_sync_snapshot
// Multi-channel control-value crossing into the pixel clock domain. Each
// channel is synchronised, stability-filtered and published once per frame.
//   clk_pixel  pixel clock, the only clock
//   rst        asynchronous active-high reset
//   bus        param_sync_snapshot_if.slave: new_frame, params_in in;
//              params_out, changed, settled out
// Optional feature: macro SLEW_LIMIT_EN (slew-limited publishing).
// ---------------------------------------------------------------------------
module param_sync_snapshot
  import param_sync_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_STEP      = DEF_MAX_STEP
) (
  input  logic                   clk_pixel,
  input  logic                   rst,
  param_sync_snapshot_if.slave   bus
);

  logic [NUM_CH*WIDTH-1:0] out_flat;
  logic [NUM_CH-1:0]       changed_vec;
  logic [NUM_CH-1:0]       ok_vec;
  logic                    settled_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    param_sync_channel #(
      .WIDTH        (WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .MAX_STEP     (MAX_STEP)
    ) u_ch (
      .clk_pixel(clk_pixel),
      .rst      (rst),
      .new_frame(bus.new_frame),
      .param_in (bus.params_in[i*WIDTH +: WIDTH]),
      .param_out(out_flat[i*WIDTH +: WIDTH]),
      .changed  (changed_vec[i]),
      .filter_ok(ok_vec[i])
    );
  end

  // settled is a registered AND over every channel's filter/publish state.
  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) settled_q <= 1'b0;
    else     settled_q <= &ok_vec;
  end

  assign bus.params_out = out_flat;
  assign bus.changed    = changed_vec;
  assign bus.settled    = settled_q;

endmodule
